// File: rtl/cell_particle_streamer.sv
// cell_particle_streamer: reads the particle count from word 0 of a cell RAM,
// then streams records 1..count downstream over valid/ready. A credit check
// bounds reads in flight plus buffered records to FIFO_DEPTH, so the 2-cycle
// RAM latency never overruns the output buffer under backpressure.
module cell_particle_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = PW + 1;
    localparam int CW = PW + 3;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH} state_t;

    state_t                  state, state_nx;
    logic                    wait_q;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    issue_cnt, issue_part, latch_cnt;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [ADDR_WIDTH-1:0]   cnt_clamped;

    logic                    rd_vld_p0, rd_vld_p1, rd_vld_p2;
    logic [ADDR_WIDTH-1:0]   idx_p0, idx_p1, idx_p2;

    logic [DATA_WIDTH-1:0]   ring_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   ring_idx  [FIFO_DEPTH];
    logic                    ring_last [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [RW-1:0]           ring_cnt;

    logic                    push, pop, head_load, ring_empty, ring_wr, ring_rd;
    logic                    push_last;
    logic [CW-1:0]           in_flight, occupancy;
    logic                    credit_ok, drain_empty;

    // Counts above the RAM depth would address past the cell; saturate them.
    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        if (raw > MAX_CNT) return MAX_CNT;
        else return raw;
    endfunction

    assign cnt_clamped = clamp_count(mem_q[ADDR_WIDTH-1:0]);
    assign mem_wren    = 1'b0;
    assign busy        = (state == RD_CNT) || (state == WAIT_CNT) ||
                         (state == STREAM) || (state == DRAIN);
    assign done        = (state == FINISH);

    // Credit: reads not yet in the buffer plus buffered records, net of this
    // cycle's pop, must leave room for one more read.
    assign pop         = out_valid && out_ready;
    assign in_flight   = CW'(rd_vld_p0) + CW'(rd_vld_p1) + CW'(rd_vld_p2);
    assign occupancy   = CW'(ring_cnt) + CW'(out_valid);
    assign credit_ok   = (in_flight + occupancy) < (CW'(FIFO_DEPTH) + CW'(pop));
    assign ring_empty  = (ring_cnt == '0);
    assign drain_empty = ring_empty && (!out_valid || pop);

    // Next-state and read-issue decode.
    always_comb begin
        state_nx   = state;
        issue_cnt  = 1'b0;
        issue_part = 1'b0;
        issue_addr = '0;
        latch_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    issue_cnt = 1'b1;
                    state_nx  = RD_CNT;
                end
            end
            RD_CNT: state_nx = WAIT_CNT;
            WAIT_CNT: begin
                // Count word is on mem_q in the second wait cycle; the first
                // particle read is launched in the same cycle it is latched.
                if (wait_q) begin
                    latch_cnt = 1'b1;
                    if (cnt_clamped == '0) begin
                        state_nx = FINISH;
                    end else begin
                        issue_part = 1'b1;
                        issue_addr = ADDR_WIDTH'(1);
                        state_nx   = (cnt_clamped == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                    end
                end
            end
            STREAM: begin
                if (credit_ok) begin
                    issue_part = 1'b1;
                    issue_addr = rd_addr;
                    if (rd_addr == particle_count) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if ((in_flight == '0) && drain_empty) state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control registers: FSM, count, RAM port and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_q         <= 1'b0;
            rd_addr        <= '0;
            particle_count <= '0;
            mem_addr       <= '0;
            mem_rden       <= 1'b0;
            rd_vld_p0      <= 1'b0;
            rd_vld_p1      <= 1'b0;
            rd_vld_p2      <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_q   <= (state == WAIT_CNT) && !wait_q;
            mem_rden <= issue_cnt || issue_part;
            if (issue_cnt)       mem_addr <= '0;
            else if (issue_part) mem_addr <= issue_addr;
            if (issue_part)      rd_addr  <= issue_addr + ADDR_WIDTH'(1);
            if (latch_cnt)       particle_count <= cnt_clamped;
            // p0: read issued to RAM
            rd_vld_p0 <= issue_part;
            // p1: RAM internal stage
            rd_vld_p1 <= rd_vld_p0;
            // p2: data present on mem_q
            rd_vld_p2 <= rd_vld_p1;
        end
    end

    // Index pipeline travelling with the read valids; gated by rd_vld_pN.
    always_ff @(posedge clk) begin
        idx_p0 <= issue_addr;
        idx_p1 <= idx_p0;
        idx_p2 <= idx_p1;
    end

    assign push      = rd_vld_p2;
    assign push_last = (idx_p2 == particle_count);
    assign head_load = !out_valid || out_ready;
    assign ring_rd   = head_load && !ring_empty;
    assign ring_wr   = push && !(head_load && ring_empty);

    // Output head register and ring pointers; a push bypasses into an empty head.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ring_cnt  <= '0;
        end else begin
            if (ring_wr) wr_ptr <= wr_ptr + PW'(1);
            if (ring_rd) rd_ptr <= rd_ptr + PW'(1);
            ring_cnt <= ring_cnt + RW'(ring_wr) - RW'(ring_rd);
            if (head_load) begin
                if (!ring_empty) begin
                    out_valid <= 1'b1;
                    out_data  <= ring_data[rd_ptr];
                    out_index <= ring_idx[rd_ptr];
                    out_last  <= ring_last[rd_ptr];
                end else if (push) begin
                    out_valid <= 1'b1;
                    out_data  <= mem_q;
                    out_index <= idx_p2;
                    out_last  <= push_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Ring storage behind the head; contents are qualified by ring_cnt.
    always_ff @(posedge clk) begin
        if (ring_wr) begin
            ring_data[wr_ptr] <= mem_q;
            ring_idx[wr_ptr]  <= idx_p2;
            ring_last[wr_ptr] <= push_last;
        end
    end

endmodule

// File: tb/tb_cell_particle_streamer.sv
// Directed bench for cell_particle_streamer with a 2-cycle-latency RAM model.
module tb_cell_particle_streamer;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, done, mem_rden, mem_wren, out_valid, out_last;
    logic [AW-1:0] particle_count, mem_addr, out_index;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] q_p1 = '0;
    logic [DW-1:0] out_data;
    logic [DW-1:0] ram [0:PN-1];

    int total = 0;
    int bad   = 0;
    int issued = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    cell_particle_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .particle_count(particle_count), .mem_addr(mem_addr), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last)
    );

    // RAM model: data appears on mem_q two cycles after the rden cycle
    always @(posedge clk) begin
        if (mem_rden) q_p1 <= ram[mem_addr];
        mem_q <= q_p1;
    end

    function automatic logic [DW-1:0] rec(input int i);
        return {32'(i) ^ 32'hA5A5_0000, 32'(i * 7 + 3), 32'(i) + 32'h3F80_0000};
    endfunction

    // Outstanding particle reads (issued minus accepted) must never exceed FD
    always @(negedge clk) begin
        #1;
        if (rst) begin
            issued = 0;
            accepted = 0;
        end else begin
            if (mem_rden && mem_addr != '0) begin
                issued++;
                total++;
                if (issued - accepted > FD) begin
                    bad++;
                    $display("FAIL overflow outstanding=%0d limit=%0d", issued - accepted, FD);
                end
            end
            if (out_valid && out_ready) accepted++;
        end
    end

    task automatic stream_collect(input int cnt_exp, input bit rnd, input int max_cyc,
                                  output int nrec, output int nbad, output int nlast,
                                  output int ndone, output int last_idx, output bit tmo);
        int expi;
        int post;
        bit seen_done;
        nrec = 0; nbad = 0; nlast = 0; ndone = 0; last_idx = 0; tmo = 1'b1;
        expi = 1; post = 0; seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) ndone++;
            if (out_valid && out_ready) begin
                nrec++;
                if (out_index !== AW'(expi) || out_data !== rec(expi) ||
                    out_last !== (expi == cnt_exp)) nbad++;
                if (out_last) begin
                    nlast++;
                    last_idx = int'(out_index);
                end
                expi++;
            end
            if (seen_done) begin
                post++;
                if (post == 4) begin
                    tmo = 1'b0;
                    break;
                end
            end
            if (done) seen_done = 1'b1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, mem_rden, mem_wren, out_valid, out_last} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, mem_rden, mem_wren, out_valid, out_last});
        end
        total++;
        if (particle_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", particle_count); end
        total++;
        if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++;
        if (out_index !== '0) begin bad++; $display("FAIL reset_index got=%0d exp=0", out_index); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count3();
        logic exp_rden, exp_valid, exp_last, exp_done, exp_busy;
        ram[0] = 96'd3;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = (n == 5);  // a start while busy must be ignored
            exp_rden  = (n == 1) || (n >= 4 && n <= 6);
            exp_valid = (n >= 7 && n <= 9);
            exp_last  = (n == 9);
            exp_done  = (n == 10);
            exp_busy  = (n >= 1 && n <= 9);
            total++;
            if (mem_rden !== exp_rden) begin
                bad++; $display("FAIL c3_rden n=%0d got=%b exp=%b", n, mem_rden, exp_rden);
            end
            if (exp_rden) begin
                total++;
                if (mem_addr !== AW'((n == 1) ? 0 : n - 3)) begin
                    bad++; $display("FAIL c3_addr n=%0d got=%0d exp=%0d", n, mem_addr, (n == 1) ? 0 : n - 3);
                end
            end
            total++;
            if (out_valid !== exp_valid) begin
                bad++; $display("FAIL c3_valid n=%0d got=%b exp=%b", n, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (out_index !== AW'(n - 6) || out_data !== rec(n - 6) || out_last !== exp_last) begin
                    bad++; $display("FAIL c3_rec n=%0d got idx=%0d last=%b data=%h exp idx=%0d last=%b data=%h",
                                    n, out_index, out_last, out_data, n - 6, exp_last, rec(n - 6));
                end
            end
            total++;
            if ({done, busy} !== {exp_done, exp_busy}) begin
                bad++; $display("FAIL c3_done_busy n=%0d got=%b%b exp=%b%b", n, done, busy, exp_done, exp_busy);
            end
            if (n == 4) begin
                total++;
                if (particle_count !== AW'(3)) begin
                    bad++; $display("FAIL c3_count got=%0d exp=3", particle_count);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_count0();
        ram[0] = 96'd0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (mem_rden !== (n == 1)) begin bad++; $display("FAIL c0_rden n=%0d got=%b exp=%b", n, mem_rden, n == 1); end
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL c0_valid n=%0d got=%b exp=0", n, out_valid); end
            total++;
            if ({done, busy} !== {n == 4, n >= 1 && n <= 3}) begin
                bad++; $display("FAIL c0_done_busy n=%0d got=%b%b exp=%b%b", n, done, busy, n == 4, n <= 3);
            end
            total++;
            if (mem_wren !== 1'b0) begin bad++; $display("FAIL c0_wren n=%0d got=%b exp=0", n, mem_wren); end
        end
    endtask

    task automatic test_backpressure();
        int reads, expi, ndone;
        ram[0] = 96'd5;
        reads = 0; expi = 1; ndone = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = (n >= 7 && n <= 16) ? 1'b0 : 1'b1;
            if (n <= 16 && mem_rden && mem_addr != '0) reads++;
            if (n >= 8 && n <= 16) begin
                total++;
                if (mem_rden !== 1'b0) begin bad++; $display("FAIL bp_stall n=%0d got=%b exp=0", n, mem_rden); end
            end
            if (n >= 7 && n <= 16) begin
                total++;
                if (out_valid !== 1'b1 || out_index !== AW'(1) || out_data !== rec(1)) begin
                    bad++; $display("FAIL bp_hold n=%0d got v=%b idx=%0d data=%h exp v=1 idx=1 data=%h",
                                    n, out_valid, out_index, out_data, rec(1));
                end
            end
            if (done) ndone++;
            if (out_valid && out_ready) begin
                total++;
                if (out_index !== AW'(expi) || out_data !== rec(expi) || out_last !== (expi == 5)) begin
                    bad++; $display("FAIL bp_order got idx=%0d last=%b exp idx=%0d last=%b", out_index, out_last, expi, expi == 5);
                end
                expi++;
            end
        end
        out_ready = 1'b1;
        total++;
        if (reads !== 4) begin bad++; $display("FAIL bp_reads got=%0d exp=4", reads); end
        total++;
        if (expi - 1 !== 5) begin bad++; $display("FAIL bp_nrec got=%0d exp=5", expi - 1); end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", ndone); end
    endtask

    task automatic test_clamp();
        int nrec, nbad, nlast, ndone, last_idx;
        bit tmo;
        ram[0] = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_ABFF};
        stream_collect(219, 1'b0, 600, nrec, nbad, nlast, ndone, last_idx, tmo);
        total++;
        if (particle_count !== AW'(219)) begin bad++; $display("FAIL clamp_count got=%0d exp=219", particle_count); end
        total++;
        if (tmo !== 1'b0) begin bad++; $display("FAIL clamp_timeout got=%b exp=0", tmo); end
        total++;
        if (nrec !== 219 || nbad !== 0) begin bad++; $display("FAIL clamp_stream got nrec=%0d nbad=%0d exp 219 0", nrec, nbad); end
        total++;
        if (nlast !== 1 || last_idx !== 219) begin bad++; $display("FAIL clamp_last got n=%0d idx=%0d exp 1 219", nlast, last_idx); end
    endtask

    task automatic test_random_ready();
        int nrec, nbad, nlast, ndone, last_idx;
        bit tmo;
        ram[0] = 96'd40;
        stream_collect(40, 1'b1, 1500, nrec, nbad, nlast, ndone, last_idx, tmo);
        total++;
        if (tmo !== 1'b0) begin bad++; $display("FAIL rnd_timeout got=%b exp=0", tmo); end
        total++;
        if (nrec !== 40 || nbad !== 0) begin bad++; $display("FAIL rnd_stream got nrec=%0d nbad=%0d exp 40 0", nrec, nbad); end
        total++;
        if (nlast !== 1 || last_idx !== 40) begin bad++; $display("FAIL rnd_last got n=%0d idx=%0d exp 1 40", nlast, last_idx); end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL rnd_done got=%0d exp=1", ndone); end
    endtask

    task automatic test_reset_mid();
        int nrec, nbad, nlast, ndone, last_idx;
        bit tmo;
        ram[0] = 96'd10;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 8) rst = 1'b1;
            if (n == 9) begin
                rst = 1'b0;
                total++;
                if ({busy, done, mem_rden, mem_wren, out_valid, out_last} !== 6'b0 || particle_count !== '0 ||
                    mem_addr !== '0 || out_data !== '0 || out_index !== '0) begin
                    bad++; $display("FAIL rm_zero got ctrl=%b cnt=%0d addr=%0d idx=%0d exp all 0",
                                    {busy, done, mem_rden, mem_wren, out_valid, out_last}, particle_count, mem_addr, out_index);
                end
            end
            if (n >= 9) begin
                total++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL rm_quiet n=%0d got v=%b busy=%b exp 0 0", n, out_valid, busy);
                end
            end
        end
        stream_collect(10, 1'b0, 200, nrec, nbad, nlast, ndone, last_idx, tmo);
        total++;
        if (tmo !== 1'b0 || ndone !== 1) begin bad++; $display("FAIL rm_restart_done got tmo=%b ndone=%0d exp 0 1", tmo, ndone); end
        total++;
        if (nrec !== 10 || nbad !== 0 || nlast !== 1 || last_idx !== 10) begin
            bad++; $display("FAIL rm_restart got nrec=%0d nbad=%0d nlast=%0d idx=%0d exp 10 0 1 10", nrec, nbad, nlast, last_idx);
        end
    endtask

    initial begin
        for (int i = 0; i < PN; i++) ram[i] = rec(i);
        test_reset();
        test_count3();
        test_count0();
        test_backpressure();
        test_clamp();
        test_random_ready();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
